// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state encoding and event bundle for button_event_gen
package button_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_PRESSED = 2'b01,
        S_LONG    = 2'b10
    } state_t;

    // "release" is a language keyword, hence released
    typedef struct packed {
        logic press;
        logic released;
        logic click;
        logic long_p;
        logic repeat_p;
    } btn_event_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/button_event_gen.sv
// rtl/button_event_gen.sv - debounced button level to press/release/click/long/repeat pulses; BUTTON_REPEAT_EN enables auto-repeat
module button_event_gen
    import button_pkg::*;
#(
    parameter int LONG_TICKS          = 1000,
    parameter int REPEAT_PERIOD_TICKS = 100,
    parameter int REPEAT_CNT_W        = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    btn_in,
    output logic                    pressed,
    output logic                    press_pulse,
    output logic                    release_pulse,
    output logic                    click_pulse,
    output logic                    long_pulse,
    output logic                    repeat_pulse,
    output logic [REPEAT_CNT_W-1:0] repeat_count
);

    localparam int CNT_W = $clog2(max_int(LONG_TICKS, REPEAT_PERIOD_TICKS)) + 1;
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);

    state_t           state;
    logic [CNT_W-1:0] counter;

`ifdef BUTTON_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_PERIOD_TICKS - 1);

    logic rep_hit;
    logic press_hit;

    // Release has priority over the repeat terminal count, so btn_in gates the hit.
    assign rep_hit   = (state == S_LONG) && btn_in && (counter == REP_LAST);
    assign press_hit = (state == S_IDLE) && btn_in;

    sat_counter #(
        .WIDTH (REPEAT_CNT_W)
    ) u_repeat_count (
        .clk   (clk),
        .rst   (rst),
        .clr   (press_hit),
        .inc   (rep_hit),
        .count (repeat_count)
    );
`else
    assign repeat_pulse = 1'b0;
    assign repeat_count = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            counter       <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            click_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
`ifdef BUTTON_REPEAT_EN
            repeat_pulse  <= 1'b0;
`endif
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            click_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
`ifdef BUTTON_REPEAT_EN
            repeat_pulse  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (btn_in) begin
                        state       <= S_PRESSED;
                        counter     <= '0;
                        pressed     <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        pressed <= 1'b0;
                    end
                end
                S_PRESSED: begin
                    if (!btn_in) begin
                        state         <= S_IDLE;
                        pressed       <= 1'b0;
                        release_pulse <= 1'b1;
                        click_pulse   <= 1'b1;
                    end else if (counter == LONG_LAST) begin
                        state      <= S_LONG;
                        counter    <= '0;
                        long_pulse <= 1'b1;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                S_LONG: begin
                    if (!btn_in) begin
                        state         <= S_IDLE;
                        pressed       <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
`ifdef BUTTON_REPEAT_EN
                        if (rep_hit) begin
                            counter      <= '0;
                            repeat_pulse <= 1'b1;
                        end else begin
                            counter <= counter + 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    counter <= '0;
                    pressed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_gen.sv
// tb/tb_button_event_gen.sv - randomized self-checking bench against a run-length event model
module tb_button_event_gen;

    localparam int LT = 8;
    localparam int RP = 4;
    localparam int W  = 2;
    localparam int MAXN = 256;
`ifdef BUTTON_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         btn_in;
    logic         pressed, press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse;
    logic [W-1:0] repeat_count;

    bit               stim [MAXN];
    logic [W+5:0]     expv [MAXN];
    logic [W+5:0]     obsv [MAXN];
    int               n;
    int               rc_m;
    int               compared   = 0;
    int               mismatched = 0;

    button_event_gen #(
        .LONG_TICKS          (LT),
        .REPEAT_PERIOD_TICKS (RP),
        .REPEAT_CNT_W        (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .click_pulse   (click_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .repeat_count  (repeat_count)
    );

    always #5 clk = ~clk;

    function automatic logic [W+5:0] obs_now();
        return {pressed, press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, repeat_count};
    endfunction

    // Each run of H ones starting at sample s yields: press at s, long at s+LT if H>LT,
    // repeats every RP after that while still held, release at s+H (click if H<=LT).
    task automatic build_model();
        bit e_pr[MAXN], e_p[MAXN], e_r[MAXN], e_c[MAXN], e_l[MAXN], e_rp[MAXN];
        int i, h;
        for (int k = 0; k < n; k++) begin
            e_pr[k] = 0; e_p[k] = 0; e_r[k] = 0; e_c[k] = 0; e_l[k] = 0; e_rp[k] = 0;
        end
        i = 0;
        while (i < n) begin
            if (stim[i]) begin
                h = 0;
                while (i + h < n && stim[i + h]) h++;
                e_p[i] = 1;
                for (int k = i; k < i + h; k++) e_pr[k] = 1;
                if (h > LT) begin
                    e_l[i + LT] = 1;
                    for (int k = 1; LT + RP * k < h; k++) if (REP_EN) e_rp[i + LT + RP * k] = 1;
                end
                if (i + h < n) begin
                    e_r[i + h] = 1;
                    e_c[i + h] = (h <= LT);
                end
                i = i + h;
            end else begin
                i++;
            end
        end
        for (int k = 0; k < n; k++) begin
            if (e_p[k]) rc_m = 0;
            if (e_rp[k] && rc_m < (1 << W) - 1) rc_m++;
            expv[k] = {e_pr[k], e_p[k], e_r[k], e_c[k], e_l[k], e_rp[k], W'(rc_m)};
        end
    endtask

    // Starts and ends just after a falling clock edge; captures one observation per sample.
    task automatic play();
        build_model();
        for (int i = 0; i < n; i++) begin
            btn_in = stim[i];
            @(posedge clk);
            @(negedge clk);
            obsv[i] = obs_now();
        end
    endtask

    task automatic load_run(input int hold, input int gap);
        for (int k = 0; k < hold; k++) begin stim[n] = 1'b1; n++; end
        for (int k = 0; k < gap; k++)  begin stim[n] = 1'b0; n++; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_in = 1'b1;
        rc_m = 0;
        repeat (3) begin
            @(negedge clk);
            compared++;
            if (obs_now() !== '0) begin
                mismatched++;
                $display("FAIL reset_hold: got %b want %b", obs_now(), {(W+6){1'b0}});
            end
        end
        rst = 1'b0;
        n = 0;
        load_run(2, 2);
        play();
        for (int i = 0; i < n; i++) begin
            compared++;
            if (obsv[i] !== expv[i]) begin
                mismatched++;
                $display("FAIL reset_release cyc %0d: got %b want %b", i, obsv[i], expv[i]);
            end
        end
    endtask

    task automatic test_click();
        n = 0;
        load_run(3, 3);
        play();
        for (int i = 0; i < n; i++) begin
            compared++;
            if (obsv[i] !== expv[i]) begin
                mismatched++;
                $display("FAIL click cyc %0d: got %b want %b", i, obsv[i], expv[i]);
            end
        end
    endtask

    task automatic test_long_repeat();
        n = 0;
        load_run(22, 3);
        load_run(1, 2);
        play();
        for (int i = 0; i < n; i++) begin
            compared++;
            if (obsv[i] !== expv[i]) begin
                mismatched++;
                $display("FAIL long_repeat cyc %0d: got %b want %b", i, obsv[i], expv[i]);
            end
        end
    endtask

    task automatic test_boundary();
        n = 0;
        load_run(LT, 2);
        load_run(LT + 1, 2);
        play();
        for (int i = 0; i < n; i++) begin
            compared++;
            if (obsv[i] !== expv[i]) begin
                mismatched++;
                $display("FAIL boundary cyc %0d: got %b want %b", i, obsv[i], expv[i]);
            end
        end
    endtask

    task automatic test_saturate();
        n = 0;
        load_run(40, 3);
        play();
        for (int i = 0; i < n; i++) begin
            compared++;
            if (obsv[i] !== expv[i]) begin
                mismatched++;
                $display("FAIL saturate cyc %0d: got %b want %b", i, obsv[i], expv[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        btn_in = 1'b1;
        repeat (LT + 4) begin
            @(posedge clk);
            @(negedge clk);
        end
        compared++;
        if (pressed !== 1'b1) begin
            mismatched++;
            $display("FAIL long_held pressed: got %b want 1", pressed);
        end
        #2 rst = 1'b1;
        #1;
        compared++;
        if (obs_now() !== '0) begin
            mismatched++;
            $display("FAIL async_reset_now: got %b want %b", obs_now(), {(W+6){1'b0}});
        end
        @(posedge clk);
        @(negedge clk);
        compared++;
        if (obs_now() !== '0) begin
            mismatched++;
            $display("FAIL async_reset_held: got %b want %b", obs_now(), {(W+6){1'b0}});
        end
        btn_in = 1'b0;
        rst = 1'b0;
        rc_m = 0;
        n = 0;
        load_run(22, 3);
        play();
        for (int i = 0; i < n; i++) begin
            compared++;
            if (obsv[i] !== expv[i]) begin
                mismatched++;
                $display("FAIL after_reset cyc %0d: got %b want %b", i, obsv[i], expv[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int iter = 0; iter < 6; iter++) begin
            n = 0;
            while (n < 180) load_run($urandom_range(1, 30), $urandom_range(1, 4));
            play();
            for (int i = 0; i < n; i++) begin
                compared++;
                if (obsv[i] !== expv[i]) begin
                    mismatched++;
                    $display("FAIL random it%0d cyc %0d: got %b want %b", iter, i, obsv[i], expv[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_click();
        test_long_repeat();
        test_boundary();
        test_saturate();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
